// File: rtl/rad_cdc_mcp_back_rx.sv
// Receive side of a toggle-handshake multi-cycle-path CDC: synchronises the request toggle,
// captures the source word once per transition and returns an acknowledge toggle on consumption.
module rad_cdc_mcp_back_rx #(
    parameter int unsigned DW          = 8,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned CW          = 16
) (
    input  logic          bclk,
    input  logic          brst,
    input  logic [DW-1:0] adata,
    input  logic          a_tgl,
    output logic [DW-1:0] b_data,
    output logic          b_valid,
    input  logic          b_ready,
    output logic          b_ack_tgl,
    output logic          b_err,
    output logic [CW-1:0] b_xfer_cnt
);

    typedef enum logic [0:0] {StWait, StReady} state_e;

    state_e                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   hist_q;
    logic                   b_en;
    logic [DW-1:0]          data_q, data_d;
    logic                   ack_q, ack_d;
    logic                   err_q, err_d;
    logic [CW-1:0]          cnt_q, cnt_d;

    always_ff @(posedge bclk or posedge brst) begin
        if (brst) begin
            sync_q <= '0;
            hist_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], a_tgl};
            hist_q <= sync_q[SYNC_STAGES-1];
        end
    end

    // One pulse per toggle transition seen at the synchroniser output.
    assign b_en = sync_q[SYNC_STAGES-1] ^ hist_q;

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        ack_d   = ack_q;
        err_d   = err_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StWait: begin
                if (b_en) begin
                    data_d  = adata;
                    state_d = StReady;
                end
            end
            StReady: begin
                // A new request while the previous word is still held is dropped and flagged.
                if (b_en) err_d = 1'b1;
                if (b_ready) begin
                    state_d = StWait;
                    ack_d   = ~ack_q;
                    cnt_d   = cnt_q + CW'(1);
                end
            end
            default: state_d = StWait;
        endcase
    end

    always_ff @(posedge bclk or posedge brst) begin
        if (brst) begin
            state_q <= StWait;
            data_q  <= '0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    assign b_data     = data_q;
    assign b_valid    = (state_q == StReady);
    assign b_ack_tgl  = ack_q;
    assign b_err      = err_q;
    assign b_xfer_cnt = cnt_q;

endmodule
